// File: rtl/axis_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_video_pkg
// Description : Shared definitions for the AXI4-Stream video demux: frame-sync
//               state encoding and the per-beat sideband tag.
// Revision    : 1.0  initial release
// ============================================================================
package axis_video_pkg;

    // Frame-sync states: SYNC drops beats until a start-of-frame is seen.
    localparam int                   c_state_w = 1;
    localparam logic [c_state_w-1:0] c_st_sync = 1'b0;
    localparam logic [c_state_w-1:0] c_st_pass = 1'b1;

    // Sideband carried with every forwarded beat. The full beat is
    // {data, tag}; data width depends on the instantiating module.
    typedef struct packed {
        logic last;
        logic user;
        logic route;
    } beat_tag_t;

endpackage
`default_nettype wire

// File: rtl/axis_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : axis_skid_buf
// Description : Two-entry ready/valid register slice (output register plus
//               skid register). Full throughput, registered upstream ready.
// Revision    : 1.0  initial release
// ============================================================================
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_in_ready;
    logic             w_in_fire;
    logic             w_out_free;
    logic             w_skid_valid_nxt;

    assign w_in_fire        = i_valid & r_in_ready;
    // Output register can take a new beat when empty or draining this cycle.
    assign w_out_free       = ~r_out_valid | i_ready;
    // Skid is emptied whenever the output frees; otherwise it captures a stalled fire.
    assign w_skid_valid_nxt = w_out_free ? 1'b0 : (r_skid_valid | w_in_fire);

    // Output/skid registers: skid has priority into the output to keep order.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b0;
        end else begin
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_data  <= r_skid_data;
                    r_out_valid <= 1'b1;
                end else begin
                    if (w_in_fire) begin
                        r_out_data <= i_data;
                    end
                    r_out_valid <= w_in_fire;
                end
            end else if (w_in_fire) begin
                r_skid_data <= i_data;
            end
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    assign o_ready = r_in_ready;
    assign o_data  = r_out_data;
    assign o_valid = r_out_valid;

endmodule
`default_nettype wire

// File: rtl/axis_video_demux.sv
`default_nettype none
// ============================================================================
// Module      : axis_video_demux
// Description : 1:2 AXI4-Stream video demultiplexer. Route is latched only on
//               accepted start-of-frame beats; beats seen before the first
//               SOF are dropped and counted. Registered output with skid.
// Revision    : 1.0  initial release
// ============================================================================
module axis_video_demux #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [DATA_WIDTH*8-1:0] s_axis_video_tdata,
    input  logic                    s_axis_video_tlast,
    input  logic                    s_axis_video_tuser,
    input  logic                    s_axis_video_tvalid,
    output logic                    s_axis_video_tready,
    output logic [DATA_WIDTH*8-1:0] m_axis_video_0_tdata,
    output logic                    m_axis_video_0_tlast,
    output logic                    m_axis_video_0_tuser,
    output logic                    m_axis_video_0_tvalid,
    input  logic                    m_axis_video_0_tready,
    output logic [DATA_WIDTH*8-1:0] m_axis_video_1_tdata,
    output logic                    m_axis_video_1_tlast,
    output logic                    m_axis_video_1_tuser,
    output logic                    m_axis_video_1_tvalid,
    input  logic                    m_axis_video_1_tready,
    input  logic                    selector,
    output logic [15:0]             drop_count
);

    import axis_video_pkg::*;

    typedef struct packed {
        logic [DATA_WIDTH*8-1:0] data;
        beat_tag_t               tag;
    } beat_t;

    localparam int c_beat_w = $bits(beat_t);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic                 r_route;
    logic                 w_route_nxt;
    logic                 w_s_fire;
    logic                 w_fwd;
    logic                 w_drop;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_out_ready;
    logic [c_beat_w-1:0]  w_out_data;
    beat_t                w_in_beat;
    beat_t                w_out_beat;
    logic [15:0]          r_drop_count;

    assign w_s_fire = s_axis_video_tvalid & w_in_ready;

    // Frame-sync state and held route register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= c_st_sync;
            r_route <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_route <= w_route_nxt;
        end
    end

    // Next state, route latch on SOF, and forward/drop decision per accepted beat.
    always_comb begin
        w_state_nxt         = r_state;
        w_route_nxt         = r_route;
        w_fwd               = 1'b0;
        w_drop              = 1'b0;
        w_in_beat.data      = s_axis_video_tdata;
        w_in_beat.tag.last  = s_axis_video_tlast;
        w_in_beat.tag.user  = s_axis_video_tuser;
        w_in_beat.tag.route = r_route;
        // The SOF beat itself already travels to the newly selected sink.
        if (w_s_fire && s_axis_video_tuser) begin
            w_route_nxt         = selector;
            w_in_beat.tag.route = selector;
        end
        case (r_state)
            c_st_sync: begin
                if (w_s_fire) begin
                    if (s_axis_video_tuser) begin
                        w_fwd       = 1'b1;
                        w_state_nxt = c_st_pass;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            c_st_pass: begin
                w_fwd = w_s_fire;
            end
            default: begin
                w_state_nxt = c_st_sync;
            end
        endcase
    end

    // Saturating count of beats discarded while waiting for frame sync.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_drop_count <= 16'd0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    // Only the sink owning the head beat can advance the output register.
    assign w_out_beat  = w_out_data;
    assign w_out_ready = w_out_beat.tag.route ? m_axis_video_1_tready : m_axis_video_0_tready;

    axis_skid_buf #(
        .WIDTH (c_beat_w)
    ) u_skid (
        .clk     (aclk),
        .aresetn (aresetn),
        .i_data  (w_in_beat),
        .i_valid (w_fwd),
        .o_ready (w_in_ready),
        .o_data  (w_out_data),
        .o_valid (w_out_valid),
        .i_ready (w_out_ready)
    );

    assign s_axis_video_tready   = w_in_ready;
    assign m_axis_video_0_tdata  = w_out_beat.data;
    assign m_axis_video_0_tlast  = w_out_beat.tag.last;
    assign m_axis_video_0_tuser  = w_out_beat.tag.user;
    assign m_axis_video_0_tvalid = w_out_valid & ~w_out_beat.tag.route;
    assign m_axis_video_1_tdata  = w_out_beat.data;
    assign m_axis_video_1_tlast  = w_out_beat.tag.last;
    assign m_axis_video_1_tuser  = w_out_beat.tag.user;
    assign m_axis_video_1_tvalid = w_out_valid & w_out_beat.tag.route;
    assign drop_count            = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_video_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_video_demux
// Description : Self-checking bench for axis_video_demux against a queue-level
//               reference model of the frame-aligned demux.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axis_video_demux;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tlast = 1'b0, s_tuser = 1'b0, s_tvalid = 1'b0, s_tready;
    logic [7:0] m0_tdata, m1_tdata;
    logic       m0_tlast, m0_tuser, m0_tvalid, m1_tlast, m1_tuser, m1_tvalid;
    logic       m0_tready = 1'b1, m1_tready = 1'b1;
    logic       selector = 1'b0;
    logic [15:0] drop_count;

    always #5 aclk = ~aclk;

    axis_video_demux #(.DATA_WIDTH(1)) dut (
        .aclk                  (aclk),
        .aresetn               (aresetn),
        .s_axis_video_tdata    (s_tdata),
        .s_axis_video_tlast    (s_tlast),
        .s_axis_video_tuser    (s_tuser),
        .s_axis_video_tvalid   (s_tvalid),
        .s_axis_video_tready   (s_tready),
        .m_axis_video_0_tdata  (m0_tdata),
        .m_axis_video_0_tlast  (m0_tlast),
        .m_axis_video_0_tuser  (m0_tuser),
        .m_axis_video_0_tvalid (m0_tvalid),
        .m_axis_video_0_tready (m0_tready),
        .m_axis_video_1_tdata  (m1_tdata),
        .m_axis_video_1_tlast  (m1_tlast),
        .m_axis_video_1_tuser  (m1_tuser),
        .m_axis_video_1_tvalid (m1_tvalid),
        .m_axis_video_1_tready (m1_tready),
        .selector              (selector),
        .drop_count            (drop_count)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       route;
    } exp_t;

    // Reference model: every forwarded beat waits in one ordered queue until
    // the sink named by its route takes it; the demux holds at most two.
    exp_t        q[$];
    logic        in_reset = 1'b1;
    logic        synced = 1'b0;
    logic        cur_route = 1'b0;
    logic [15:0] drops = 16'd0;
    logic        checking = 1'b0;
    logic        accepted = 1'b0;
    logic        rnd_rdy = 1'b0;
    int          stall = 0;
    int          gap_max = 0;
    int          total = 0, bad = 0;
    int          cyc = 0, rx0 = 0, rx1 = 0, max_q = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare DUT to model mid-cycle, then advance the model.
    task automatic tick();
        logic exp_rdy, pop;
        exp_t b;
        @(negedge aclk);
        exp_rdy = !in_reset && (q.size() < 2);
        if (checking) begin
            chk("s_tready", {31'd0, s_tready}, {31'd0, exp_rdy});
            chk("drop_count", {16'd0, drop_count}, {16'd0, drops});
            if (in_reset || q.size() == 0) begin
                chk("m0_tvalid", {31'd0, m0_tvalid}, 32'd0);
                chk("m1_tvalid", {31'd0, m1_tvalid}, 32'd0);
            end else begin
                b = q[0];
                chk("m0_tvalid", {31'd0, m0_tvalid}, {31'd0, !b.route});
                chk("m1_tvalid", {31'd0, m1_tvalid}, {31'd0, b.route});
                if (b.route)
                    chk("m1_beat", {22'd0, m1_tdata, m1_tlast, m1_tuser}, {22'd0, b.data, b.last, b.user});
                else
                    chk("m0_beat", {22'd0, m0_tdata, m0_tlast, m0_tuser}, {22'd0, b.data, b.last, b.user});
            end
            if (in_reset) begin
                chk("rst_m0_bus", {22'd0, m0_tdata, m0_tlast, m0_tuser}, 32'd0);
                chk("rst_m1_bus", {22'd0, m1_tdata, m1_tlast, m1_tuser}, 32'd0);
            end
        end
        if (q.size() > max_q) max_q = q.size();
        pop = 1'b0;
        if (!in_reset && q.size() > 0) pop = q[0].route ? m1_tready : m0_tready;
        accepted = s_tvalid && exp_rdy && aresetn;
        if (!aresetn) begin
            q.delete();
            in_reset = 1'b1;
            synced = 1'b0;
            cur_route = 1'b0;
            drops = 16'd0;
        end else begin
            in_reset = 1'b0;
            if (pop) begin
                b = q.pop_front();
                if (b.route) rx1++; else rx0++;
            end
            if (accepted) begin
                if (!synced && !s_tuser) begin
                    if (drops != 16'hFFFF) drops++;
                end else begin
                    if (s_tuser) begin
                        cur_route = selector;
                        synced = 1'b1;
                    end
                    b.data = s_tdata; b.last = s_tlast; b.user = s_tuser; b.route = cur_route;
                    q.push_back(b);
                end
            end
        end
        cyc++;
        @(posedge aclk);
        #1;
        if (stall > 0) begin
            stall--;
            m0_tready = 1'b0;
            m1_tready = 1'b1;
        end else if (rnd_rdy) begin
            m0_tready = 1'($urandom);
            m1_tready = 1'($urandom);
        end else begin
            m0_tready = 1'b1;
            m1_tready = 1'b1;
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l, input logic u, input logic sel);
        int n;
        s_tvalid = 1'b0;
        repeat ($urandom_range(0, gap_max)) tick();
        s_tdata = d; s_tlast = l; s_tuser = u; selector = sel; s_tvalid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 200);
        chk("accept_in_time", {31'd0, accepted}, 32'd1);
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input int lines, input int width,
                              input logic sel0, input int sw, input logic sel1);
        for (int i = 0; i < lines * width; i++)
            send_beat(base + 8'(i), (i % width) == width - 1, i == 0, (i >= sw) ? sel1 : sel0);
    endtask

    task automatic do_reset(input int n);
        aresetn = 1'b0;
        repeat (n) tick();
        aresetn = 1'b1;
    endtask

    initial begin
        int r0, r1, c0, nf;
        logic [7:0] base;
        // Reset held with input valid asserted.
        s_tvalid = 1'b1;
        aresetn  = 1'b0;
        tick();
        checking = 1'b1;
        repeat (3) tick();
        aresetn  = 1'b1;
        s_tvalid = 1'b0;
        tick();
        tick();
        chk("ready_after_release", {31'd0, s_tready}, 32'd1);

        // Unsynchronised beats are dropped, then a 4x2 frame to sink 0.
        r0 = rx0; r1 = rx1;
        send_beat(8'h11, 1'b0, 1'b0, 1'b0);
        send_beat(8'h22, 1'b0, 1'b0, 1'b0);
        send_beat(8'h33, 1'b1, 1'b0, 1'b1);
        send_frame(8'hA0, 4, 2, 1'b0, 99, 1'b0);
        repeat (4) tick();
        chk("sync_drops", {16'd0, drop_count}, 32'd3);
        chk("sync_rx0", rx0 - r0, 8);
        chk("sync_rx1", rx1 - r1, 0);

        // Selector flips mid-frame; only the next frame moves to sink 1.
        r0 = rx0; r1 = rx1;
        send_frame(8'hB0, 4, 2, 1'b0, 3, 1'b1);
        send_frame(8'hC0, 2, 3, 1'b1, 99, 1'b1);
        repeat (4) tick();
        chk("switch_rx0", rx0 - r0, 8);
        chk("switch_rx1", rx1 - r1, 6);

        // Sink 0 stalled for 5 cycles under continuous input; sink 1 ready is ignored.
        max_q = 0;
        m0_tready = 1'b0;
        m1_tready = 1'b1;
        stall = 4;
        r0 = rx0;
        send_frame(8'h40, 2, 6, 1'b0, 99, 1'b0);
        repeat (4) tick();
        chk("bp_max_held", max_q, 2);
        chk("bp_rx0", rx0 - r0, 12);

        // Reset in the middle of a frame, then two strays before the next SOF.
        send_beat(8'h60, 1'b0, 1'b1, 1'b1);
        send_beat(8'h61, 1'b0, 1'b0, 1'b1);
        send_beat(8'h62, 1'b0, 1'b0, 1'b1);
        send_beat(8'h63, 1'b0, 1'b0, 1'b1);
        s_tdata = 8'h64; s_tvalid = 1'b1;
        do_reset(2);
        s_tvalid = 1'b0;
        r0 = rx0;
        send_beat(8'h71, 1'b0, 1'b0, 1'b0);
        send_beat(8'h72, 1'b1, 1'b0, 1'b0);
        send_frame(8'h80, 1, 4, 1'b0, 99, 1'b0);
        repeat (4) tick();
        chk("rst_mid_drops", {16'd0, drop_count}, 32'd2);
        chk("rst_mid_rx0", rx0 - r0, 4);

        // 64 beats back to back: one accepted beat per cycle, nothing dropped.
        do_reset(2);
        tick();
        r1 = rx1;
        c0 = cyc;
        send_frame(8'h00, 8, 8, 1'b1, 99, 1'b1);
        chk("tput_cycles", cyc - c0, 64);
        repeat (4) tick();
        chk("tput_rx1", rx1 - r1, 64);
        chk("tput_drops", {16'd0, drop_count}, 32'd0);

        // Randomised frames, selectors, gaps and sink readiness.
        rnd_rdy = 1'b1;
        gap_max = 2;
        nf = 8;
        for (int f = 0; f < nf; f++) begin
            base = 8'($urandom);
            send_frame(base, $urandom_range(1, 3), $urandom_range(1, 4), 1'($urandom),
                       $urandom_range(1, 6), 1'($urandom));
        end
        rnd_rdy = 1'b0;
        gap_max = 0;
        repeat (8) tick();
        chk("final_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
